// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: transmitter states, flag/abort patterns, CRC-16 constants.
// Pure declarations; no timing or flow-control behaviour of its own.
package hdlc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START_FLAG,
        ST_DATA,
        ST_FCS,
        ST_END_FLAG,
        ST_ABORT
    } tx_state_e;

    localparam logic [7:0]  FLAG          = 8'h7E;
    localparam logic [7:0]  ABORT         = 8'hFE;
    localparam logic [15:0] CRC_POLY      = 16'h1021;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;
    localparam int          MAX_BYTES_DEF = 126;
    localparam logic [2:0]  STUFF_RUN     = 3'd5;

    // The line is LSB first, so the CRC register shifts right with the mirrored polynomial.
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i] = v[15-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hdlc_tx_fcs.sv
// Serial CRC-16 (x^16+x^12+x^5+1) over LSB-first bits; register updates one cycle after bit_vld_i.
// No backpressure: a bit is consumed on every cycle bit_vld_i is high; clr_i wins over bit_vld_i.
module hdlc_tx_fcs
    import hdlc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clr_i,
    input  logic        bit_vld_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    localparam logic [15:0] POLY_REFL = reflect16(CRC_POLY);

    logic [15:0] crc_q, crc_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        fb    = crc_q[0] ^ bit_i;
        if (clr_i) begin
            crc_d = CRC_INIT;
        end else if (bit_vld_i) begin
            crc_d = {1'b0, crc_q[15:1]} ^ (fb ? POLY_REFL : 16'h0000);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: buffers bytes, then sends flag/stuffed data/FCS/flag one bit per cycle.
// First flag bit appears the cycle after Tx_Enable; writes are dropped outside IDLE or when full.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEF
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_WrBuff,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic       Tx_FCSen,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_Full,
    output logic       Tx_AbortedTrans,
    output logic [7:0] Tx_FrameSize
);

    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    tx_state_e   state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  fcs_cnt_q, fcs_cnt_d;
    logic [7:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  size_q, size_d;
    logic [2:0]  ones_q, ones_d;
    logic        fcs_en_q, fcs_en_d;
    logic [7:0]  mem_q [MAX_BYTES];

    logic        wr_en;
    logic [7:0]  cur_byte;
    logic [15:0] crc;
    logic        crc_clr, crc_vld, crc_bit;
    logic        stuff;
    logic        tx_bit, valid, aborted;

    assign cur_byte = mem_q[byte_idx_q[AW-1:0]];
    assign stuff    = (ones_q == STUFF_RUN);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        fcs_cnt_d  = fcs_cnt_q;
        byte_idx_d = byte_idx_q;
        size_d     = size_q;
        ones_d     = ones_q;
        fcs_en_d   = fcs_en_q;
        tx_bit     = 1'b1;
        valid      = 1'b0;
        aborted    = 1'b0;
        crc_clr    = 1'b0;
        crc_vld    = 1'b0;
        crc_bit    = 1'b0;
        wr_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                crc_clr   = 1'b1;
                ones_d    = 3'd0;
                bit_cnt_d = 3'd0;
                wr_en     = Tx_WrBuff && !Tx_Full;
                if (wr_en) begin
                    size_d = size_q + 8'd1;
                end
                if (Tx_Enable && (size_q != 8'd0)) begin
                    state_d  = ST_START_FLAG;
                    fcs_en_d = Tx_FCSen;
                end
            end

            ST_START_FLAG: begin
                valid     = 1'b1;
                tx_bit    = FLAG[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (Tx_AbortFrame) begin
                    state_d   = ST_ABORT;
                    bit_cnt_d = 3'd0;
                end else if (bit_cnt_q == 3'd7) begin
                    state_d    = ST_DATA;
                    byte_idx_d = 8'd0;
                end
            end

            ST_DATA, ST_FCS: begin
                valid = 1'b1;
                if (stuff) begin
                    // Inserted zero: payload position and CRC stay put.
                    tx_bit = 1'b0;
                    ones_d = 3'd0;
                end else begin
                    tx_bit = (state_q == ST_DATA) ? cur_byte[bit_cnt_q] : ~crc[fcs_cnt_q];
                    ones_d = tx_bit ? ones_q + 3'd1 : 3'd0;
                    if (state_q == ST_DATA) begin
                        crc_vld   = 1'b1;
                        crc_bit   = tx_bit;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_idx_d = byte_idx_q + 8'd1;
                            if (byte_idx_q == size_q - 8'd1) begin
                                state_d   = fcs_en_q ? ST_FCS : ST_END_FLAG;
                                fcs_cnt_d = 4'd0;
                            end
                        end
                    end else begin
                        fcs_cnt_d = fcs_cnt_q + 4'd1;
                        if (fcs_cnt_q == 4'd15) begin
                            state_d = ST_END_FLAG;
                        end
                    end
                end
                if (Tx_AbortFrame) begin
                    state_d   = ST_ABORT;
                    bit_cnt_d = 3'd0;
                end
            end

            ST_END_FLAG: begin
                valid = 1'b1;
                // A payload ending in five ones still owes its stuffed zero before the flag.
                if ((bit_cnt_q == 3'd0) && stuff) begin
                    tx_bit = 1'b0;
                    ones_d = 3'd0;
                end else begin
                    tx_bit    = FLAG[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_IDLE;
                        size_d  = 8'd0;
                    end
                end
            end

            ST_ABORT: begin
                valid     = 1'b1;
                tx_bit    = ABORT[bit_cnt_q];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    aborted = 1'b1;
                    state_d = ST_IDLE;
                    size_d  = 8'd0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            fcs_cnt_q  <= 4'd0;
            byte_idx_q <= 8'd0;
            size_q     <= 8'd0;
            ones_q     <= 3'd0;
            fcs_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            fcs_cnt_q  <= fcs_cnt_d;
            byte_idx_q <= byte_idx_d;
            size_q     <= size_d;
            ones_q     <= ones_d;
            fcs_en_q   <= fcs_en_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[size_q[AW-1:0]] <= Tx_Data;
        end
    end

    hdlc_tx_fcs u_fcs (
        .clk_i     (Clk),
        .rst_n_i   (Rst),
        .clr_i     (crc_clr),
        .bit_vld_i (crc_vld),
        .bit_i     (crc_bit),
        .crc_o     (crc)
    );

    assign Tx              = tx_bit;
    assign Tx_ValidFrame   = valid;
    assign Tx_AbortedTrans = aborted;
    assign Tx_Done         = (state_q == ST_IDLE) && (size_q == 8'd0);
    assign Tx_Full         = (size_q == 8'(MAX_BYTES));
    assign Tx_FrameSize    = size_q;

endmodule
